// File: rtl/bcd_scan_counter_if.sv
// Control and display signals of the BCD scan counter.
// The master drives the count controls and the slave (the counter) drives the outputs.
interface bcd_scan_counter_if;
  logic        clr;
  logic        load;
  logic [15:0] load_val;
  logic        inc;
  logic        dir;
  logic [15:0] count;
  logic        carry;
  logic        load_err;
  logic [3:0]  digit_sel;
  logic [3:0]  digit_out;

  modport master (
    output clr, load, load_val, inc, dir,
    input  count, carry, load_err, digit_sel, digit_out
  );

  modport slave (
    input  clr, load, load_val, inc, dir,
    output count, carry, load_err, digit_sel, digit_out
  );
endinterface

// File: rtl/bcd_scan_counter.sv
// 4-digit packed-BCD up/down counter with a free-running, time-multiplexed digit scanner
// that feeds a downstream BCD-to-7-segment decoder.
module bcd_scan_counter #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned BLANK_LZ = 1
) (
  input logic               clk,
  input logic               rst_n,
  bcd_scan_counter_if.slave bus
);

  localparam int unsigned DivW = $clog2(SCAN_DIV) + 1;
  localparam logic [DivW-1:0] DivMax = DivW'(SCAN_DIV - 1);

  logic [15:0]     count_q, count_d;
  logic            carry_q, carry_d;
  logic            load_err_q, load_err_d;
  logic [3:0]      sel_q, sel_d;
  logic [DivW-1:0] div_q, div_d;

  logic [15:0] count_up, count_dn;
  logic        en_up, en_dn;
  logic [3:0]  nib;
  logic        load_ok;
  logic [3:0]  digit_out_d;

  // Ripple enables: a nibble steps only when every lower nibble is at its rollover value.
  always_comb begin
    count_up = count_q;
    count_dn = count_q;
    en_up    = 1'b1;
    en_dn    = 1'b1;
    nib      = '0;
    for (int i = 0; i < 4; i++) begin
      nib = count_q[4*i +: 4];
      if (en_up) count_up[4*i +: 4] = (nib == 4'd9) ? 4'd0 : nib + 4'd1;
      if (en_dn) count_dn[4*i +: 4] = (nib == 4'd0) ? 4'd9 : nib - 4'd1;
      en_up = en_up & (nib == 4'd9);
      en_dn = en_dn & (nib == 4'd0);
    end
  end

  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (bus.load_val[4*i +: 4] > 4'd9) load_ok = 1'b0;
    end
  end

  always_comb begin
    count_d    = count_q;
    carry_d    = 1'b0;
    load_err_d = 1'b0;
    if (bus.clr) begin
      count_d = '0;
    end else if (bus.load) begin
      if (load_ok) count_d = bus.load_val;
      else         load_err_d = 1'b1;
    end else if (bus.inc) begin
      count_d = bus.dir ? count_up : count_dn;
      carry_d = bus.dir ? en_up : en_dn;
    end
  end

  always_comb begin
    div_d = div_q + 1'b1;
    sel_d = sel_q;
    if (div_q == DivMax) begin
      div_d = '0;
      sel_d = {sel_q[2:0], sel_q[3]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q    <= '0;
      carry_q    <= 1'b0;
      load_err_q <= 1'b0;
      sel_q      <= 4'b0001;
      div_q      <= '0;
    end else begin
      count_q    <= count_d;
      carry_q    <= carry_d;
      load_err_q <= load_err_d;
      sel_q      <= sel_d;
      div_q      <= div_d;
    end
  end

  // Position k blanks when it and every higher nibble are zero; the ones digit never blanks.
  always_comb begin
    digit_out_d = count_q[3:0];
    unique case (sel_q)
      4'b0010: begin
        digit_out_d = count_q[7:4];
        if (BLANK_LZ != 0 && count_q[15:4] == 12'd0) digit_out_d = 4'hF;
      end
      4'b0100: begin
        digit_out_d = count_q[11:8];
        if (BLANK_LZ != 0 && count_q[15:8] == 8'd0) digit_out_d = 4'hF;
      end
      4'b1000: begin
        digit_out_d = count_q[15:12];
        if (BLANK_LZ != 0 && count_q[15:12] == 4'd0) digit_out_d = 4'hF;
      end
      default: digit_out_d = count_q[3:0];
    endcase
  end

  assign bus.count     = count_q;
  assign bus.carry     = carry_q;
  assign bus.load_err  = load_err_q;
  assign bus.digit_sel = sel_q;
  assign bus.digit_out = digit_out_d;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Scoreboard bench: a decimal reference model queues the expected state for every driven cycle,
// and each entry is popped and compared after the following clock edge.
module tb_bcd_scan_counter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bcd_scan_counter_if bus ();
  bcd_scan_counter_if bus_nb ();

  assign bus_nb.clr      = bus.clr;
  assign bus_nb.load     = bus.load;
  assign bus_nb.load_val = bus.load_val;
  assign bus_nb.inc      = bus.inc;
  assign bus_nb.dir      = bus.dir;

  bcd_scan_counter #(.SCAN_DIV(4), .BLANK_LZ(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  bcd_scan_counter #(.SCAN_DIV(4), .BLANK_LZ(0)) dut_nb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_nb.slave)
  );

  typedef struct {
    logic [15:0] count;
    logic        carry;
    logic        load_err;
    logic [3:0]  sel;
    logic [3:0]  dout;
    logic [3:0]  dout_nb;
  } exp_t;

  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;

  int m_count = 0;
  int m_sel   = 0;
  int m_div   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int from_bcd(input logic [15:0] b);
    return 1000 * int'(b[15:12]) + 100 * int'(b[11:8]) + 10 * int'(b[7:4]) + int'(b[3:0]);
  endfunction

  function automatic logic valid_bcd(input logic [15:0] b);
    logic [15:0] t;
    t = b;
    for (int i = 0; i < 4; i++) begin
      if (t[3:0] > 4'd9) return 1'b0;
      t = t >> 4;
    end
    return 1'b1;
  endfunction

  // One cycle: drive, advance the model, queue its expectation, then compare after the edge.
  task automatic step(input logic rn, input logic c, input logic l, input logic [15:0] lv,
                      input logic i, input logic d);
    exp_t        e;
    logic [15:0] b;
    int          pow;
    rst_n        = rn;
    bus.clr      = c;
    bus.load     = l;
    bus.load_val = lv;
    bus.inc      = i;
    bus.dir      = d;
    e.carry      = 1'b0;
    e.load_err   = 1'b0;
    if (!rn) begin
      m_count = 0;
      m_sel   = 0;
      m_div   = 0;
    end else begin
      if (c) begin
        m_count = 0;
      end else if (l) begin
        if (valid_bcd(lv)) m_count = from_bcd(lv);
        else e.load_err = 1'b1;
      end else if (i) begin
        if (d) begin
          e.carry = (m_count == 9999);
          m_count = (m_count + 1) % 10000;
        end else begin
          e.carry = (m_count == 0);
          m_count = (m_count + 9999) % 10000;
        end
      end
      if (m_div == 3) begin
        m_div = 0;
        m_sel = (m_sel + 1) % 4;
      end else begin
        m_div++;
      end
    end
    b         = to_bcd(m_count);
    e.count   = b;
    e.sel     = 4'(1 << m_sel);
    b         = b >> (4 * m_sel);
    e.dout_nb = b[3:0];
    pow       = (m_sel == 0) ? 1 : (m_sel == 1) ? 10 : (m_sel == 2) ? 100 : 1000;
    e.dout    = (m_sel != 0 && m_count < pow) ? 4'hF : b[3:0];
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("count", 32'(bus.count), 32'(e.count));
    check("carry", 32'(bus.carry), 32'(e.carry));
    check("load_err", 32'(bus.load_err), 32'(e.load_err));
    check("digit_sel", 32'(bus.digit_sel), 32'(e.sel));
    check("digit_out", 32'(bus.digit_out), 32'(e.dout));
    check("digit_out_nolz", 32'(bus_nb.digit_out), 32'(e.dout_nb));
    check("count_nolz", 32'(bus_nb.count), 32'(e.count));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic do_load(input logic [15:0] v);
    step(1'b1, 1'b0, 1'b1, v, 1'b0, 1'b0);
  endtask

  initial begin
    logic [15:0] rv;
    rst_n        = 1'b0;
    bus.clr      = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = 16'h0;
    bus.inc      = 1'b0;
    bus.dir      = 1'b0;

    // Reset.
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);

    // Digit ripple and scanned display with leading-zero blanking.
    do_load(16'h0199);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    idle(16);

    // Wrap in both directions.
    do_load(16'h9999);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    idle(1);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    idle(1);

    // Rejected and accepted loads.
    do_load(16'h12A4);
    idle(1);
    do_load(16'h1234);
    do_load(16'hF000);

    // Priority.
    step(1'b1, 1'b1, 1'b1, 16'h0777, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 16'h0500, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 16'h05B0, 1'b1, 1'b1);

    // Reset mid-scan with a non-zero count.
    do_load(16'h0042);
    for (int k = 0; k < 16 && m_sel != 2; k++) idle(1);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    idle(5);

    // No-blanking instance shows every digit.
    do_load(16'h0007);
    idle(16);

    // Random traffic including invalid loads and occasional reset.
    for (int k = 0; k < 400; k++) begin
      rv = ($urandom_range(0, 1) == 0) ? to_bcd(int'($urandom_range(0, 9999)))
                                        : 16'($urandom);
      step(($urandom_range(0, 60) != 0), ($urandom_range(0, 30) == 0),
           ($urandom_range(0, 6) == 0), rv, ($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
